i2c_master_write: RTL and testbench

I2C_MASTER_WRITE -- requirements
Module: i2c_master

---
 rtl/i2c_master_write.sv | 147 ++++++++++++++
 tb/tb_i2c_master_write.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_write.sv
// Write-only I2C master: START, address+W, sub-address, data byte, STOP.
// Each bit slot is four quarter-bit ticks; a NACK on any ACK slot aborts straight to STOP.
module i2c_master_write #(
  parameter int DELAY = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] sub,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic       i2c_sda_out,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_out_mode,
  output logic       i2c_scl
);

  localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CW-1:0] TICK_TOP = CW'(DELAY - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK1, SUB, ACK2, DATA, ACK3, STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    sub_q, sub_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          tick;

  assign tick = (cnt_q == TICK_TOP);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Slot sequencing: every state lasts a whole number of 4-tick slots; decisions happen on the q3 tick.
  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sub_d   = sub_q;
    data_d  = data_q;
    done_d  = 1'b0;
    if (tick) begin
      if (state_q == IDLE) begin
        if (start) begin
          state_d = START;
          qtr_d   = 2'd0;
          bit_d   = 3'd0;
          shift_d = {addr, 1'b0};
          sub_d   = sub;
          data_d  = data;
        end
      end else begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd3) begin
          case (state_q)
            START: state_d = ADDR;
            ADDR, SUB, DATA: begin
              shift_d = {shift_q[6:0], 1'b0};
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                if (state_q == ADDR)     state_d = ACK1;
                else if (state_q == SUB) state_d = ACK2;
                else                     state_d = ACK3;
              end
            end
            ACK1: begin
              state_d = i2c_sda_in ? STOP : SUB;
              shift_d = sub_q;
            end
            ACK2: begin
              state_d = i2c_sda_in ? STOP : DATA;
              shift_d = data_q;
            end
            ACK3: state_d = STOP;
            STOP: begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
            default: state_d = IDLE;
          endcase
        end
      end
    end
  end

  // Line levels are decoded from registered state, so they only move on tick edges.
  always_comb begin
    i2c_scl          = 1'b1;
    i2c_sda_out      = 1'b1;
    i2c_sda_out_mode = 1'b1;
    case (state_q)
      START: begin
        i2c_scl     = (qtr_q != 2'd3);
        i2c_sda_out = (qtr_q == 2'd0);
      end
      ADDR, SUB, DATA: begin
        i2c_scl     = qtr_q[1];
        i2c_sda_out = shift_q[7];
      end
      ACK1, ACK2, ACK3: begin
        i2c_scl          = qtr_q[1];
        i2c_sda_out_mode = 1'b0;
      end
      STOP: begin
        i2c_scl     = (qtr_q != 2'd0);
        i2c_sda_out = qtr_q[1];
      end
      default: ;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      qtr_q   <= 2'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      sub_q   <= 8'd0;
      data_q  <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sub_q   <= sub_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_write.sv
// Bench for i2c_master_write: a bus monitor reassembles bytes on SCL rising edges
// and pops expected bytes from a scoreboard queue filled when each transaction is launched.
module tb_i2c_master_write;
  localparam int DELAY = 2;
  localparam int FULL_CLKS = 116 * DELAY;
  localparam int NACK_CLKS = 44 * DELAY;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [6:0] addr;
  logic [7:0] sub, data;
  logic       ready, done, sda_out, sda_in, mode, scl;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         start_seen = 0;
  int         stop_seen  = 0;
  int         done_seen  = 0;
  int         bit_idx    = 0;
  logic [7:0] shreg      = 8'd0;
  logic       prev_scl   = 1'b1;
  logic       prev_sda   = 1'b1;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] sub;
    logic [7:0] data;
    logic       nack;
    int         exp_clks;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  i2c_master_write #(.DELAY(DELAY)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .addr             (addr),
    .sub              (sub),
    .data             (data),
    .ready            (ready),
    .done             (done),
    .i2c_sda_out      (sda_out),
    .i2c_sda_in       (sda_in),
    .i2c_sda_out_mode (mode),
    .i2c_scl          (scl)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Bus monitor: bits on SCL rise, 9th bit must be released, START/STOP by SDA edges with SCL high.
  always @(negedge clk) begin
    if (done) done_seen++;
    if (ready) begin
      bit_idx = 0;
    end else if (!prev_scl && scl) begin
      if (bit_idx < 8) begin
        shreg = {shreg[6:0], sda_out};
        checkOutput("mode_data_bit", mode, 1);
        bit_idx++;
      end else begin
        checkOutput("mode_ack_bit", mode, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL byte: got %02h expected none", shreg);
        end else begin
          checkOutput("byte", shreg, exp_q.pop_front());
        end
        bit_idx = 0;
      end
    end
    if (prev_scl && scl && prev_sda && !sda_out) start_seen++;
    if (prev_scl && scl && !prev_sda && sda_out) stop_seen++;
    prev_scl = scl;
    prev_sda = sda_out;
  end

  task automatic applyStimulus(input vec_t v, input bit push_all, input bit hold_start);
    sda_in = v.nack;
    addr   = v.addr;
    sub    = v.sub;
    data   = v.data;
    exp_q.push_back({v.addr, 1'b0});
    if (push_all && !v.nack) begin
      exp_q.push_back(v.sub);
      exp_q.push_back(v.data);
    end
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!ready) break;
    end
    if (ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL launch: got ready=1 expected ready=0 within 100 clks");
    end
    if (!hold_start) start = 1'b0;
    addr = 7'($urandom);
    sub  = 8'($urandom);
    data = 8'($urandom);
  endtask

  task automatic measureDone(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (!done) $display("[TB] no done pulse within 1000 clks");
  endtask

  initial begin
    int n;
    int stops_before;
    int done_before;
    vec_t v;

    vecs[0] = '{addr: 7'b1010101, sub: 8'hAA, data: 8'hAA, nack: 1'b0, exp_clks: FULL_CLKS};
    vecs[1] = '{addr: 7'h68,      sub: 8'h20, data: 8'h0F, nack: 1'b0, exp_clks: FULL_CLKS};
    vecs[2] = '{addr: 7'h3C,      sub: 8'h12, data: 8'h34, nack: 1'b1, exp_clks: NACK_CLKS};
    vecs[3] = '{addr: 7'h00,      sub: 8'hFF, data: 8'h01, nack: 1'b0, exp_clks: FULL_CLKS};
    vecs[4] = '{addr: 7'h7F,      sub: 8'h00, data: 8'h80, nack: 1'b0, exp_clks: FULL_CLKS};

    reset  = 1'b1;
    start  = 1'b0;
    addr   = 7'd0;
    sub    = 8'd0;
    data   = 8'd0;
    sda_in = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_scl", scl, 1);
    checkOutput("reset_sda", sda_out, 1);
    checkOutput("reset_mode", mode, 1);
    checkOutput("reset_ready", ready, 1);
    checkOutput("reset_done", done, 0);

    for (int i = 0; i < 5; i++) begin
      stops_before = stop_seen;
      applyStimulus(vecs[i], 1'b1, 1'b0);
      measureDone(n);
      checkOutput("done_latency", n, vecs[i].exp_clks);
      checkOutput("ready_at_done", ready, 1);
      @(negedge clk);
      checkOutput("done_width", done, 0);
      checkOutput("stop_count", stop_seen, stops_before + 1);
      checkOutput("bytes_left", exp_q.size(), 0);
    end

    // Reset partway through the sub-address byte.
    v = '{addr: 7'h2A, sub: 8'h5C, data: 8'h33, nack: 1'b0, exp_clks: FULL_CLKS};
    applyStimulus(v, 1'b0, 1'b0);
    repeat (90) @(negedge clk);
    done_before = done_seen;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_scl", scl, 1);
    checkOutput("midreset_sda", sda_out, 1);
    checkOutput("midreset_mode", mode, 1);
    checkOutput("midreset_ready", ready, 1);
    checkOutput("midreset_done", done, 0);
    repeat (300) @(negedge clk);
    checkOutput("midreset_no_done", done_seen, done_before);
    checkOutput("midreset_bytes_left", exp_q.size(), 0);
    checkOutput("midreset_still_idle", ready, 1);

    // Start held high: second transaction follows at the first tick after done.
    v = '{addr: 7'h11, sub: 8'h22, data: 8'h33, nack: 1'b0, exp_clks: FULL_CLKS};
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h22);
    applyStimulus(v, 1'b1, 1'b1);
    addr = 7'h11;
    sub  = 8'h22;
    data = 8'h33;
    exp_q.delete();
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    measureDone(n);
    checkOutput("b2b_first_latency", n, FULL_CLKS);
    checkOutput("b2b_ready_at_done", ready, 1);
    @(negedge clk);
    checkOutput("b2b_wait_tick", ready, 1);
    @(negedge clk);
    checkOutput("b2b_restart", ready, 0);
    start = 1'b0;
    measureDone(n);
    checkOutput("b2b_second_latency", n, FULL_CLKS);
    checkOutput("b2b_bytes_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
